// File: rtl/clock_set_ctrl_pkg.sv
// Shared types and constants for the time-of-day set controller.
//   clk_mode_t : controller mode, also the encoding driven on the mode output
//   MAX_*      : inclusive upper bounds of the time fields
//   HALF_DAY   : hour offset applied by the AM/PM flip
//   *_W        : field widths of the sec/min/hr registers
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } clk_mode_t;

  localparam int unsigned MAX_SEC  = 59;
  localparam int unsigned MAX_MIN  = 59;
  localparam int unsigned MAX_HR   = 23;
  localparam int unsigned HALF_DAY = 12;
  localparam int unsigned SEC_W    = 6;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned HR_W     = 5;

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Bundle between the set controller and its environment (buttons + time datapath).
//   btn_mode/btn_inc/btn_ampm : raw, asynchronous, bouncy buttons
//   cur_min/cur_hr            : current time from the datapath
//   sec_tick                  : one-cycle seconds-advance enable
//   load, load_min, load_hr   : one-cycle atomic load of the edited time
//   mode, blink               : current mode and display blink phase
// slave  : the controller side
// master : the datapath/button side (and the testbench)
interface clock_set_ctrl_if;
  import clock_pkg::*;

  logic             btn_mode;
  logic             btn_inc;
  logic             btn_ampm;
  logic [MIN_W-1:0] cur_min;
  logic [HR_W-1:0]  cur_hr;
  logic             sec_tick;
  logic             load;
  logic [MIN_W-1:0] load_min;
  logic [HR_W-1:0]  load_hr;
  logic [1:0]       mode;
  logic             blink;

  modport slave (
    input  btn_mode, btn_inc, btn_ampm, cur_min, cur_hr,
    output sec_tick, load, load_min, load_hr, mode, blink
  );

  modport master (
    output btn_mode, btn_inc, btn_ampm, cur_min, cur_hr,
    input  sec_tick, load, load_min, load_hr, mode, blink
  );

endinterface

// File: rtl/clock_set_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
//   clk, rst : system clock, asynchronous active-high reset
//   raw      : raw button level
//   pulse    : one-cycle pulse per accepted press (press-to-pulse 2 + DEB_CYCLES + 1 clk)
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;
  logic            level_dly_q;
  logic            pulse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], raw};
      level_dly_q <= level_q;
      pulse_q     <= level_q & ~level_dly_q;
      // Any return to the accepted level restarts the stability window.
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/sequencing controller for the 24 h time-of-day datapath.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : slave side of clock_set_ctrl_if (buttons, current time in;
//              sec_tick, load strobe + edited time, mode, blink out)
// Generates the seconds enable from a free-running prescaler, conditions the
// buttons and runs RUN -> SET_HR -> SET_MIN -> COMMIT on an edit copy of hr/min.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned DEB_CYCLES = 16
) (
  input logic             clk,
  input logic             rst,
  clock_set_ctrl_if.slave bus
);

  localparam int unsigned PresW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(TICK_DIV - 1);

  logic p_mode, p_inc, p_ampm;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk  (clk),
    .rst  (rst),
    .raw  (bus.btn_mode),
    .pulse(p_mode)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk  (clk),
    .rst  (rst),
    .raw  (bus.btn_inc),
    .pulse(p_inc)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ampm (
    .clk  (clk),
    .rst  (rst),
    .raw  (bus.btn_ampm),
    .pulse(p_ampm)
  );

  clk_mode_t        mode_q;
  logic [PresW-1:0] presc_q;
  logic             sec_tick_q;
  logic             load_q;
  logic             blink_q;
  logic [HR_W-1:0]  edit_hr_q;
  logic [MIN_W-1:0] edit_min_q;
  logic             wrap;

  assign wrap = (presc_q == PresMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= RUN;
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
      load_q     <= 1'b0;
      blink_q    <= 1'b0;
      edit_hr_q  <= '0;
      edit_min_q <= '0;
    end else begin
      presc_q    <= wrap ? '0 : presc_q + PresW'(1);
      sec_tick_q <= 1'b0;
      load_q     <= 1'b0;
      case (mode_q)
        RUN: begin
          blink_q <= 1'b0;
          if (p_mode) begin
            // Leaving RUN suppresses the tick so time is frozen from the first SET cycle.
            mode_q     <= SET_HR;
            edit_hr_q  <= (bus.cur_hr > HR_W'(MAX_HR)) ? '0 : bus.cur_hr;
            edit_min_q <= (bus.cur_min > MIN_W'(MAX_MIN)) ? '0 : bus.cur_min;
          end else begin
            sec_tick_q <= wrap;
          end
        end
        SET_HR: begin
          if (wrap) blink_q <= ~blink_q;
          if (p_mode) begin
            mode_q <= SET_MIN;
          end else if (p_ampm) begin
            edit_hr_q <= (edit_hr_q < HR_W'(HALF_DAY)) ? edit_hr_q + HR_W'(HALF_DAY)
                                                       : edit_hr_q - HR_W'(HALF_DAY);
          end else if (p_inc) begin
            edit_hr_q <= (edit_hr_q == HR_W'(MAX_HR)) ? '0 : edit_hr_q + HR_W'(1);
          end
        end
        SET_MIN: begin
          if (wrap) blink_q <= ~blink_q;
          if (p_mode) begin
            // Restart the prescaler so the first committed second is a full period.
            mode_q  <= COMMIT;
            load_q  <= 1'b1;
            presc_q <= '0;
          end else if (p_inc && !p_ampm) begin
            edit_min_q <= (edit_min_q == MIN_W'(MAX_MIN)) ? '0 : edit_min_q + MIN_W'(1);
          end
        end
        COMMIT: begin
          mode_q  <= RUN;
          blink_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sec_tick = sec_tick_q;
  assign bus.load     = load_q;
  assign bus.load_min = edit_min_q;
  assign bus.load_hr  = edit_hr_q;
  assign bus.mode     = mode_q;
  assign bus.blink    = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  clock_set_ctrl_if bus_if ();

  clock_set_ctrl #(
    .TICK_DIV  (4),
    .DEB_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int errors = 0;
  int checks = 0;

  // Observation state gathered every cycle by step().
  int cyc = 0;
  int loads, set_ticks, both_cnt;
  int load_cyc, first_tick, mode_after_load;
  int load_hr_seen, load_min_seen, load_mode_seen;

  task automatic clear_obs();
    loads = 0; set_ticks = 0; both_cnt = 0;
    load_cyc = -10; first_tick = -1; mode_after_load = -1;
    load_hr_seen = -1; load_min_seen = -1; load_mode_seen = -1;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (cyc == load_cyc + 1) mode_after_load = int'(bus_if.mode);
    if ((bus_if.mode == 2'd1 || bus_if.mode == 2'd2) && bus_if.sec_tick) set_ticks++;
    if (bus_if.sec_tick && bus_if.load) both_cnt++;
    if (bus_if.sec_tick && first_tick < 0 && load_cyc >= 0 && cyc > load_cyc) first_tick = cyc;
    if (bus_if.load) begin
      loads++;
      load_cyc       = cyc;
      first_tick     = -1;
      load_hr_seen   = int'(bus_if.load_hr);
      load_min_seen  = int'(bus_if.load_min);
      load_mode_seen = int'(bus_if.mode);
    end
  endtask

  // Hold the selected buttons long enough to be accepted, then release and settle.
  task automatic press(input bit m, input bit i, input bit a);
    bus_if.btn_mode = m;
    bus_if.btn_inc  = i;
    bus_if.btn_ampm = a;
    repeat (8) step();
    bus_if.btn_mode = 1'b0;
    bus_if.btn_inc  = 1'b0;
    bus_if.btn_ampm = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.btn_mode = 1'b0;
    bus_if.btn_inc  = 1'b0;
    bus_if.btn_ampm = 1'b0;
    bus_if.cur_hr   = 5'd0;
    bus_if.cur_min  = 6'd0;
    clear_obs();
    repeat (3) step();
    checks++; if (bus_if.sec_tick !== 1'b0) begin errors++;
      $display("FAIL reset_sec_tick: got %b expected 0", bus_if.sec_tick); end
    checks++; if (bus_if.load !== 1'b0) begin errors++;
      $display("FAIL reset_load: got %b expected 0", bus_if.load); end
    checks++; if (bus_if.load_min !== 6'd0) begin errors++;
      $display("FAIL reset_load_min: got %0d expected 0", bus_if.load_min); end
    checks++; if (bus_if.load_hr !== 5'd0) begin errors++;
      $display("FAIL reset_load_hr: got %0d expected 0", bus_if.load_hr); end
    checks++; if (bus_if.mode !== 2'd0) begin errors++;
      $display("FAIL reset_mode: got %0d expected 0", bus_if.mode); end
    checks++; if (bus_if.blink !== 1'b0) begin errors++;
      $display("FAIL reset_blink: got %b expected 0", bus_if.blink); end
  endtask

  task automatic test_run();
    logic exp_tick;
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_tick = (k % 4 == 0);
      checks++; if (bus_if.sec_tick !== exp_tick) begin errors++;
        $display("FAIL run_tick[%0d]: got %b expected %b", k, bus_if.sec_tick, exp_tick); end
      checks++; if (bus_if.mode !== 2'd0 || bus_if.load !== 1'b0) begin errors++;
        $display("FAIL run_idle[%0d]: got mode=%0d load=%b expected mode=0 load=0",
                 k, bus_if.mode, bus_if.load); end
    end
  endtask

  task automatic test_edit_path();
    bus_if.cur_hr  = 5'd10;
    bus_if.cur_min = 6'd59;
    clear_obs();
    press(1, 0, 0);
    checks++; if (bus_if.mode !== 2'd1) begin errors++;
      $display("FAIL edit_enter_sethr: got %0d expected 1", bus_if.mode); end
    checks++; if (bus_if.load_hr !== 5'd10) begin errors++;
      $display("FAIL edit_capture_hr: got %0d expected 10", bus_if.load_hr); end
    press(0, 1, 0);
    checks++; if (bus_if.load_hr !== 5'd11) begin errors++;
      $display("FAIL edit_inc_hr: got %0d expected 11", bus_if.load_hr); end
    press(1, 0, 0);
    checks++; if (bus_if.mode !== 2'd2) begin errors++;
      $display("FAIL edit_enter_setmin: got %0d expected 2", bus_if.mode); end
    press(0, 1, 0);
    press(1, 0, 0);
    checks++; if (loads !== 1) begin errors++;
      $display("FAIL edit_load_count: got %0d expected 1", loads); end
    checks++; if (load_hr_seen !== 11 || load_min_seen !== 0) begin errors++;
      $display("FAIL edit_load_value: got hr=%0d min=%0d expected hr=11 min=0",
               load_hr_seen, load_min_seen); end
    checks++; if (load_mode_seen !== 3 || mode_after_load !== 0) begin errors++;
      $display("FAIL edit_commit_mode: got %0d then %0d expected 3 then 0",
               load_mode_seen, mode_after_load); end
    checks++; if (set_ticks !== 0 || both_cnt !== 0) begin errors++;
      $display("FAIL edit_frozen: got set_ticks=%0d overlap=%0d expected 0 and 0",
               set_ticks, both_cnt); end
    checks++; if (first_tick - load_cyc !== 4) begin errors++;
      $display("FAIL edit_first_tick: got %0d clk after load expected 4",
               first_tick - load_cyc); end
    checks++; if (bus_if.mode !== 2'd0 || bus_if.blink !== 1'b0) begin errors++;
      $display("FAIL edit_back_run: got mode=%0d blink=%b expected 0 and 0",
               bus_if.mode, bus_if.blink); end
  endtask

  task automatic test_wraps();
    bus_if.cur_hr  = 5'd23;
    bus_if.cur_min = 6'd59;
    press(1, 0, 0);
    checks++; if (bus_if.load_hr !== 5'd23) begin errors++;
      $display("FAIL wrap_capture: got %0d expected 23", bus_if.load_hr); end
    press(0, 1, 0);
    checks++; if (bus_if.load_hr !== 5'd0) begin errors++;
      $display("FAIL wrap_hr_23: got %0d expected 0", bus_if.load_hr); end
    repeat (5) press(0, 1, 0);
    checks++; if (bus_if.load_hr !== 5'd5) begin errors++;
      $display("FAIL wrap_hr_to5: got %0d expected 5", bus_if.load_hr); end
    press(0, 0, 1);
    checks++; if (bus_if.load_hr !== 5'd17) begin errors++;
      $display("FAIL wrap_ampm_5: got %0d expected 17", bus_if.load_hr); end
    press(0, 0, 1);
    checks++; if (bus_if.load_hr !== 5'd5) begin errors++;
      $display("FAIL wrap_ampm_17: got %0d expected 5", bus_if.load_hr); end
    press(1, 0, 0);
    checks++; if (bus_if.load_min !== 6'd59) begin errors++;
      $display("FAIL wrap_min_capture: got %0d expected 59", bus_if.load_min); end
    press(0, 1, 0);
    checks++; if (bus_if.load_min !== 6'd0) begin errors++;
      $display("FAIL wrap_min_59: got %0d expected 0", bus_if.load_min); end
    press(1, 0, 0);
    checks++; if (bus_if.mode !== 2'd0) begin errors++;
      $display("FAIL wrap_back_run: got %0d expected 0", bus_if.mode); end
    // Out-of-range datapath values are captured as zero.
    bus_if.cur_hr  = 5'd25;
    bus_if.cur_min = 6'd63;
    press(1, 0, 0);
    checks++; if (bus_if.load_hr !== 5'd0 || bus_if.load_min !== 6'd0) begin errors++;
      $display("FAIL wrap_out_of_range: got hr=%0d min=%0d expected 0 and 0",
               bus_if.load_hr, bus_if.load_min); end
    press(1, 0, 0);
    press(1, 0, 0);
  endtask

  task automatic test_bounce();
    bus_if.cur_hr  = 5'd3;
    bus_if.cur_min = 6'd0;
    press(1, 0, 0);
    checks++; if (bus_if.load_hr !== 5'd3) begin errors++;
      $display("FAIL bounce_capture: got %0d expected 3", bus_if.load_hr); end
    for (int i = 0; i < 10; i++) begin
      bus_if.btn_inc = ~bus_if.btn_inc;
      step();
    end
    bus_if.btn_inc = 1'b1;
    repeat (12) step();
    bus_if.btn_inc = 1'b0;
    repeat (8) step();
    checks++; if (bus_if.load_hr !== 5'd4 || bus_if.mode !== 2'd1) begin errors++;
      $display("FAIL bounce_single_inc: got hr=%0d mode=%0d expected hr=4 mode=1",
               bus_if.load_hr, bus_if.mode); end
    press(1, 0, 0);
    press(1, 0, 0);
  endtask

  task automatic test_priority();
    bus_if.cur_hr  = 5'd7;
    bus_if.cur_min = 6'd30;
    clear_obs();
    press(1, 0, 0);
    press(1, 1, 0);
    checks++; if (bus_if.mode !== 2'd2 || bus_if.load_hr !== 5'd7) begin errors++;
      $display("FAIL prio_mode_wins: got mode=%0d hr=%0d expected mode=2 hr=7",
               bus_if.mode, bus_if.load_hr); end
    press(1, 0, 0);
    checks++; if (loads !== 1 || load_hr_seen !== 7 || load_min_seen !== 30) begin errors++;
      $display("FAIL prio_commit: got loads=%0d hr=%0d min=%0d expected 1, 7, 30",
               loads, load_hr_seen, load_min_seen); end
  endtask

  task automatic test_reset_mid_edit();
    bus_if.cur_hr  = 5'd8;
    bus_if.cur_min = 6'd15;
    press(1, 0, 0);
    press(1, 0, 0);
    checks++; if (bus_if.mode !== 2'd2 || bus_if.load_hr !== 5'd8) begin errors++;
      $display("FAIL midrst_setup: got mode=%0d hr=%0d expected mode=2 hr=8",
               bus_if.mode, bus_if.load_hr); end
    clear_obs();
    rst = 1'b1;
    step();
    checks++; if (bus_if.mode !== 2'd0 || bus_if.load !== 1'b0 || bus_if.sec_tick !== 1'b0)
    begin errors++;
      $display("FAIL midrst_ctrl: got mode=%0d load=%b tick=%b expected 0, 0, 0",
               bus_if.mode, bus_if.load, bus_if.sec_tick); end
    checks++; if (bus_if.load_hr !== 5'd0 || bus_if.load_min !== 6'd0 || bus_if.blink !== 1'b0)
    begin errors++;
      $display("FAIL midrst_data: got hr=%0d min=%0d blink=%b expected 0, 0, 0",
               bus_if.load_hr, bus_if.load_min, bus_if.blink); end
    rst = 1'b0;
    repeat (20) step();
    checks++; if (loads !== 0 || bus_if.mode !== 2'd0) begin errors++;
      $display("FAIL midrst_no_load: got loads=%0d mode=%0d expected 0 and 0",
               loads, bus_if.mode); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_edit_path();
    test_wraps();
    test_bounce();
    test_priority();
    test_reset_mid_edit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
